// File: rtl/mod_addsub_seq_if.sv
// Request/response bundle for the limb-serial modular adder/subtractor.
// The requester drives operands and out_ready; the arithmetic block drives
// in_ready, out_valid and the result.
interface mod_addsub_seq_if #(
  parameter int WIDTH = 256
);
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, r
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, r
  );
endinterface

// File: rtl/mod_addsub_seq.sv
// Sequential limb-serial modular adder/subtractor: r = (a +/- b) mod P.
// One LIMB_W+1-bit adder is time-shared between the raw pass (a +/- b) and
// the correction pass (raw -/+ P). Operands and the raw value live in shift
// registers so the adder always works on bit 0 of the current limb.
module mod_addsub_seq #(
  parameter int               WIDTH  = 256,
  parameter int               LIMB_W = 64,
  parameter logic [WIDTH-1:0] P      = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic             clk,
  input  logic             rst,
  mod_addsub_seq_if.slave  bus
);

  localparam int NLIMB = WIDTH / LIMB_W;
  localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NLIMB - 1);

  // Reject configurations that cannot be split into whole limbs or a zero modulus.
  generate
    if ((WIDTH % LIMB_W) != 0) begin : g_bad_limb
      $error("mod_addsub_seq: WIDTH must be a multiple of LIMB_W");
    end
    if (P == '0) begin : g_bad_mod
      $error("mod_addsub_seq: modulus P must be non-zero");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_PASS1, S_PASS2, S_DONE} state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic [WIDTH-1:0] r_raw;
  logic [WIDTH-1:0] r_t;
  logic [CW-1:0]    r_cnt;
  logic             r_cb;   // carry (add direction) or borrow (subtract direction)
  logic             r_c1;   // final carry/borrow of the raw pass

  logic [LIMB_W-1:0] w_p_limb [NLIMB];
  logic [LIMB_W-1:0] w_x;
  logic [LIMB_W-1:0] w_y;
  logic              w_sub;
  logic              w_cin;
  logic [LIMB_W:0]   w_sum;
  logic              w_flag;
  logic              w_last;
  logic              w_sel_t;
  logic [WIDTH-1:0]  w_raw_shift;
  logic [WIDTH-1:0]  w_raw_rot;
  logic [WIDTH-1:0]  w_t_shift;

  // Split the constant modulus into limbs for the correction pass.
  generate
    for (genvar gi = 0; gi < NLIMB; gi++) begin : g_plimb
      assign w_p_limb[gi] = P[gi*LIMB_W +: LIMB_W];
    end
  endgenerate

  // Shared limb adder: subtraction is x + ~y + !borrow, so one carry chain covers both.
  always_comb begin
    w_sub   = (r_state == S_PASS1) ? r_op : ~r_op;
    w_x     = (r_state == S_PASS1) ? r_a[LIMB_W-1:0] : r_raw[LIMB_W-1:0];
    w_y     = (r_state == S_PASS1) ? r_b[LIMB_W-1:0] : w_p_limb[r_cnt];
    w_cin   = w_sub ? ~r_cb : r_cb;
    w_sum   = {1'b0, w_x} + {1'b0, (w_sub ? ~w_y : w_y)} + {{LIMB_W{1'b0}}, w_cin};
    w_flag  = w_sub ? ~w_sum[LIMB_W] : w_sum[LIMB_W];
    w_last  = (r_cnt == LAST);
    // Add: take raw-P when the sum overflowed or raw >= P. Sub: add P back on borrow.
    w_sel_t = r_op ? r_c1 : (r_c1 | ~w_flag);
  end

  // New limbs enter at the top so the full value is in order after NLIMB steps.
  generate
    if (NLIMB == 1) begin : g_single
      assign w_raw_shift = w_sum[LIMB_W-1:0];
      assign w_raw_rot   = r_raw;
      assign w_t_shift   = w_sum[LIMB_W-1:0];
    end else begin : g_multi
      assign w_raw_shift = {w_sum[LIMB_W-1:0], r_raw[WIDTH-1:LIMB_W]};
      assign w_raw_rot   = {r_raw[LIMB_W-1:0], r_raw[WIDTH-1:LIMB_W]};
      assign w_t_shift   = {w_sum[LIMB_W-1:0], r_t[WIDTH-1:LIMB_W]};
    end
  endgenerate

  // Control FSM and datapath registers; reset wins over every handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 1'b0;
      r_raw       <= '0;
      r_t         <= '0;
      r_cnt       <= '0;
      r_cb        <= 1'b0;
      r_c1        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_op       <= bus.op;
            r_cnt      <= '0;
            r_cb       <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_PASS1;
          end
        end
        S_PASS1: begin
          r_a   <= r_a >> LIMB_W;
          r_b   <= r_b >> LIMB_W;
          r_raw <= w_raw_shift;
          if (w_last) begin
            r_c1    <= w_flag;
            r_cb    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_PASS2;
          end else begin
            r_cb  <= w_flag;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PASS2: begin
          r_raw <= w_raw_rot;
          r_t   <= w_t_shift;
          r_cb  <= w_flag;
          if (w_last) begin
            r_result    <= w_sel_t ? w_t_shift : w_raw_rot;
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.r         = r_result;

endmodule

// File: tb/tb_mod_addsub_seq.sv
// Bench for mod_addsub_seq: three instances (LIMB_W = 64, 256, 32) share one
// stimulus stream and are checked against a plain-arithmetic modular model.
module tb_mod_addsub_seq;
  localparam int W = 256;
  localparam logic [W-1:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam int NDUT = 3;
  localparam int LAT [NDUT] = '{8, 2, 16};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         tb_in_valid = 1'b0;
  logic         tb_op = 1'b0;
  logic         tb_out_ready = 1'b1;
  logic [W-1:0] tb_a = '0;
  logic [W-1:0] tb_b = '0;

  logic [NDUT-1:0] ov;
  logic [NDUT-1:0] ir;
  logic [W-1:0]    rr [NDUT];

  int checks = 0;
  int errors = 0;

  mod_addsub_seq_if #(.WIDTH(W)) ifs [NDUT] ();

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      localparam int LW = (gi == 0) ? 64 : ((gi == 1) ? 256 : 32);
      assign ifs[gi].in_valid  = tb_in_valid;
      assign ifs[gi].op        = tb_op;
      assign ifs[gi].a         = tb_a;
      assign ifs[gi].b         = tb_b;
      assign ifs[gi].out_ready = tb_out_ready;
      assign ov[gi]            = ifs[gi].out_valid;
      assign ir[gi]            = ifs[gi].in_ready;
      assign rr[gi]            = ifs[gi].r;
      mod_addsub_seq #(.WIDTH(W), .LIMB_W(LW), .P(P)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifs[gi])
      );
    end
  endgenerate

  // Reference: exact modular arithmetic on a one-bit-wider value.
  function automatic logic [W-1:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    if (!op) s = {1'b0, a} + {1'b0, b};
    else     s = {1'b0, a} + {1'b0, P} - {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_lt_p();
    logic [W-1:0] x;
    for (int i = 0; i < W/32; i++) x[i*32 +: 32] = $urandom;
    if (x >= P) x = x - P;
    return x;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op to all instances with out_ready high; check latency, pulse width and result.
  task automatic run_op(input string tag, input logic op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input bit chk_r);
    int           lat [NDUT];
    int           hi  [NDUT];
    logic [W-1:0] got [NDUT];
    for (int i = 0; i < NDUT; i++) begin
      lat[i] = 0;
      hi[i]  = 0;
      got[i] = 'x;
    end
    tb_in_valid  = 1'b1;
    tb_op        = op;
    tb_a         = a;
    tb_b         = b;
    tb_out_ready = 1'b1;
    check({tag, "_in_ready"}, W'(ir), W'({NDUT{1'b1}}));
    @(posedge clk);
    @(negedge clk);
    tb_in_valid = 1'b0;
    tb_op       = ~op;
    tb_a        = rnd_lt_p();
    tb_b        = rnd_lt_p();
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        if (ov[i]) begin
          if (hi[i] == 0) begin
            lat[i] = k;
            got[i] = rr[i];
          end
          hi[i]++;
        end
      end
    end
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("%s_lat%0d", tag, i), W'(lat[i]), W'(LAT[i]));
      check($sformatf("%s_pulse%0d", tag, i), W'(hi[i]), W'(1));
      if (chk_r) check($sformatf("%s_r%0d", tag, i), got[i], exp);
    end
    $display("op %s mode=%0d a=%h b=%h r=%h lat=%0d/%0d/%0d", tag, op, a, b, got[0], lat[0], lat[1], lat[2]);
  endtask

  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic         rop;
  logic [W-1:0] rexp;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", W'(ir), W'({NDUT{1'b1}}));
    check("rst_out_valid", W'(ov), '0);
    for (int i = 0; i < NDUT; i++) check($sformatf("rst_r%0d", i), rr[i], '0);
    rst = 1'b0;
    @(negedge clk);

    // Directed add/sub cases including the S == P and 2^256-carry boundaries
    run_op("add_2_3",    1'b0, W'(2),     W'(3),     W'(5),     1'b1);
    run_op("add_pm1_1",  1'b0, P - 1,     W'(1),     '0,        1'b1);
    run_op("add_pm1x2",  1'b0, P - 1,     P - 1,     P - 2,     1'b1);
    run_op("sub_5_3",    1'b1, W'(5),     W'(3),     W'(2),     1'b1);
    run_op("sub_0_1",    1'b1, '0,        W'(1),     P - 1,     1'b1);
    run_op("sub_eq",     1'b1, W'(16'h1234), W'(16'h1234), '0,  1'b1);

    // Out-of-range operands: result unspecified, but the op must complete
    run_op("add_ovr",    1'b0, '1,        '1,        '0,        1'b0);

    // Backpressure with in_valid pulses while busy
    ra = rnd_lt_p();
    rb = rnd_lt_p();
    rexp = model(1'b0, ra, rb);
    tb_in_valid  = 1'b1;
    tb_op        = 1'b0;
    tb_a         = ra;
    tb_b         = rb;
    tb_out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tb_in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      tb_in_valid = (k <= 3);
      tb_a        = rnd_lt_p();
      tb_op       = 1'b1;
      check($sformatf("bp_busy_ready_k%0d", k), W'(ir), '0);
    end
    tb_in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check("bp_hold_valid", W'(ov), W'({NDUT{1'b1}}));
      check("bp_hold_ready", W'(ir), '0);
      for (int i = 0; i < NDUT; i++) check($sformatf("bp_hold_r%0d", i), rr[i], rexp);
      @(posedge clk);
      @(negedge clk);
    end
    tb_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_rel_valid", W'(ov), '0);
    check("bp_rel_ready", W'(ir), W'({NDUT{1'b1}}));
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_valid", W'(ov), '0);
    check("bp_idle_ready", W'(ir), W'({NDUT{1'b1}}));
    $display("op backpressure a=%h b=%h r=%h", ra, rb, rr[0]);

    // Reset during the correction pass of the default instance
    tb_in_valid = 1'b1;
    tb_op       = 1'b0;
    tb_a        = rnd_lt_p();
    tb_b        = rnd_lt_p();
    @(posedge clk);
    @(negedge clk);
    tb_in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", W'(ir), W'({NDUT{1'b1}}));
    check("mid_rst_valid", W'(ov), '0);
    for (int i = 0; i < NDUT; i++) check($sformatf("mid_rst_r%0d", i), rr[i], '0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_no_pulse", W'(ov), '0);
    end
    $display("op reset-abort");
    run_op("add_7_8", 1'b0, W'(7), W'(8), W'(15), 1'b1);

    // Random operands below P against the reference model
    for (int n = 0; n < 10; n++) begin
      ra  = rnd_lt_p();
      rb  = rnd_lt_p();
      rop = 1'($urandom_range(0, 1));
      if (n == 8) rb = ra;
      rexp = model(rop, ra, rb);
      run_op($sformatf("rand%0d", n), rop, ra, rb, rexp, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
